bypass_table_serializer: RTL and testbench

- Downstream stage of the adaptive model.
- After the encoding pass, it drains the model's bypass table (24-bit entries {symbol[7:0], range[15:0]}) through the model's read_en / entry_out / entry_valid_out port.
- It emits the table as a framed byte stream with a valid/ready handshake.
- The arithmetic coder output mux consumes this stream ahead of the coded payload.

---
 rtl/bypass_table_serializer_if.sv | 28 ++
 rtl/bypass_table_serializer.sv | 115 +++++++++++
 tb/tb_bypass_table_serializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bypass_table_serializer_if.sv
// bypass_table_serializer_if: control, table read port and framed byte stream
// of the bypass table serializer.
interface bypass_table_serializer_if #(
    parameter int COUNT_W = 9,
    parameter int ENTRY_W = 24
);
    logic               start_in;
    logic [COUNT_W-1:0] entry_count_in;
    logic               read_en_out;
    logic [ENTRY_W-1:0] entry_in;
    logic               entry_valid_in;
    logic [7:0]         byte_out;
    logic               byte_valid_out;
    logic               byte_ready_in;
    logic               busy_out;
    logic               done_out;
    logic               error_out;

    modport master (
        input  start_in, entry_count_in, entry_in, entry_valid_in, byte_ready_in,
        output read_en_out, byte_out, byte_valid_out, busy_out, done_out, error_out
    );

    modport slave (
        output start_in, entry_count_in, entry_in, entry_valid_in, byte_ready_in,
        input  read_en_out, byte_out, byte_valid_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/bypass_table_serializer.sv
// bypass_table_serializer: drains the model bypass table and emits it as a framed
// byte stream (2 count header bytes, then symbol/range_hi/range_lo per entry).
module bypass_table_serializer #(
    parameter int COUNT_W  = 9,
    parameter int ENTRY_W  = 24,
    parameter int MAX_WAIT = 15
) (
    input logic clk,
    input logic rst,
    bypass_table_serializer_if.master bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, FETCH, WAIT, SEND, DONE} state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d, idx_q, idx_d, idx_inc;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [ENTRY_W-1:0] hold_q, hold_d;
    logic [1:0]         sel_q, sel_d;
    logic [7:0]         byte_q, byte_d;
    logic               valid_q, valid_d, error_q, error_d, fire;

    assign fire    = valid_q & bus.byte_ready_in;
    assign idx_inc = idx_q + COUNT_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        error_d = error_q;
        case (state_q)
            IDLE: if (bus.start_in) begin
                count_d = bus.entry_count_in;
                idx_d   = '0;
                error_d = 1'b0;
                byte_d  = {7'b0, bus.entry_count_in[COUNT_W-1]};
                valid_d = 1'b1;
                state_d = HDR0;
            end
            HDR0: if (fire) begin
                byte_d  = count_q[7:0];
                state_d = HDR1;
            end
            HDR1: if (fire) begin
                valid_d = 1'b0;
                state_d = (count_q == '0) ? DONE : FETCH;
            end
            FETCH: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.entry_valid_in) begin
                hold_d  = bus.entry_in;
                sel_d   = 2'd0;
                byte_d  = bus.entry_in[ENTRY_W-1 -: 8];
                valid_d = 1'b1;
                state_d = SEND;
            end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                error_d = 1'b1;
                state_d = DONE;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
            // The next byte is loaded at the handshake so byte_out stays registered.
            SEND: if (fire) begin
                sel_d  = sel_q + 2'd1;
                byte_d = (sel_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
                if (sel_q == 2'd2) begin
                    valid_d = 1'b0;
                    idx_d   = idx_inc;
                    state_d = (idx_inc == count_q) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign bus.read_en_out    = (state_q == FETCH);
    assign bus.byte_out       = byte_q;
    assign bus.byte_valid_out = valid_q;
    assign bus.busy_out       = (state_q != IDLE);
    assign bus.done_out       = (state_q == DONE);
    assign bus.error_out      = error_q;
endmodule

// File: tb/tb_bypass_table_serializer.sv
// tb_bypass_table_serializer: directed frames against a byte scoreboard fed from a
// 1-cycle-latency table model; ready patterns, read timeout and mid-frame reset.
module tb_bypass_table_serializer;
    localparam int MAX_WAIT = 15;
    localparam int STALL    = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bypass_table_serializer_if bus ();
    bypass_table_serializer dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0, n_fail = 0;
    int cyc = 0, rbase = 0, rmode = 0;
    int reads = 0, first_rd = 0, last_rd = 0, hs = 0, last_hs = 0, dones = 0, done_cyc = 0;
    int ptr = 0;
    bit mute = 1'b0, pend = 1'b0, stall_prev = 1'b0;
    logic [7:0]  stall_byte;
    logic [7:0]  q[$];
    logic [23:0] tbl[256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Ready pattern, table model and scoreboard monitor, all evaluated at negedge.
    always @(negedge clk) begin
        logic [7:0] exp;
        cyc++;
        bus.byte_ready_in = (rmode == 0) ? 1'b1 :
                            ((cyc - rbase) >= STALL && (cyc - rbase) < STALL + 4) ? 1'b0 :
                            ((cyc - rbase) % 2 == 0);
        bus.entry_valid_in = pend & !mute;
        if (pend) begin
            bus.entry_in = tbl[ptr];
            ptr++;
        end
        pend = bus.read_en_out;
        if (bus.read_en_out) begin
            if (reads == 0) first_rd = cyc;
            last_rd = cyc;
            reads++;
        end
        if (stall_prev) begin
            chk("stall_valid", 32'(bus.byte_valid_out), 32'd1);
            chk("stall_byte", 32'(bus.byte_out), 32'(stall_byte));
        end
        stall_prev = bus.byte_valid_out & !bus.byte_ready_in;
        stall_byte = bus.byte_out;
        if (bus.byte_valid_out && bus.byte_ready_in) begin
            exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
            chk("byte", 32'(bus.byte_out), 32'(exp));
            hs++;
            last_hs = cyc;
        end
        if (bus.done_out) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic start_frame(input int cnt, input int mode, input bit mute_i);
        logic [8:0] c9;
        c9 = 9'(cnt);
        ptr = 0; reads = 0; hs = 0; mute = mute_i; rmode = mode;
        q.delete();
        q.push_back({7'b0, c9[8]});
        q.push_back(c9[7:0]);
        if (!mute_i)
            for (int i = 0; i < cnt; i++) begin
                q.push_back(tbl[i][23:16]);
                q.push_back(tbl[i][15:8]);
                q.push_back(tbl[i][7:0]);
            end
        tick();
        rbase = cyc;
        bus.start_in = 1'b1;
        bus.entry_count_in = c9;
        tick();
        bus.start_in = 1'b0;
        chk("start_lat_valid", 32'(bus.byte_valid_out), 32'd1);
        chk("start_hdr0", 32'(bus.byte_out), 32'({7'b0, c9[8]}));
        chk("start_clr_err", 32'(bus.error_out), 32'd0);
    endtask

    task automatic run(input int cnt, input int mode, input bit mute_i);
        int d0;
        d0 = dones;
        start_frame(cnt, mode, mute_i);
        for (int k = 0; k < 20 * cnt + 100 && dones == d0; k++) tick();
        chk("done_pulse", 32'(dones - d0), 32'd1);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        if (mute_i) begin
            chk("to_bytes", 32'(hs), 32'd2);
            chk("to_reads", 32'(reads), 32'd1);
            chk("to_error", 32'(bus.error_out), 32'd1);
            chk("to_cycles", 32'(done_cyc - first_rd), 32'(MAX_WAIT + 1));
        end else begin
            chk("byte_total", 32'(hs), 32'(2 + 3 * cnt));
            chk("read_pulses", 32'(reads), 32'(cnt));
            chk("done_after_hs", 32'(done_cyc - last_hs), 32'd1);
            chk("no_error", 32'(bus.error_out), 32'd0);
            if (mode == 0 && cnt >= 2)
                chk("entry_cycles", 32'(last_rd - first_rd), 32'(5 * (cnt - 1)));
        end
        tick();
        chk("idle_busy", 32'(bus.busy_out), 32'd0);
        chk("idle_done", 32'(bus.done_out), 32'd0);
        if (mute_i) chk("err_sticky", 32'(bus.error_out), 32'd1);
    endtask

    initial begin
        int d0;
        bus.start_in = 1'b0;
        bus.entry_count_in = '0;
        bus.entry_in = '0;
        bus.entry_valid_in = 1'b0;
        bus.byte_ready_in = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_valid", 32'(bus.byte_valid_out), 32'd0);
        chk("rst_byte", 32'(bus.byte_out), 32'd0);
        chk("rst_read", 32'(bus.read_en_out), 32'd0);
        chk("rst_done", 32'(bus.done_out), 32'd0);
        chk("rst_error", 32'(bus.error_out), 32'd0);
        rst = 1'b1;
        tick();

        run(0, 0, 1'b0);

        tbl[0] = {8'h41, 16'h0003};
        tbl[1] = {8'h7A, 16'h0010};
        run(2, 0, 1'b0);
        run(2, 1, 1'b0);

        for (int i = 0; i < 256; i++) tbl[i] = {8'(i), 16'(i + 1)};
        run(256, 0, 1'b0);

        run(3, 0, 1'b1);
        run(0, 0, 1'b0);

        // Mid-frame reset with a start pulse while busy.
        tbl[0] = {8'h41, 16'h0003};
        tbl[1] = {8'h7A, 16'h0010};
        d0 = dones;
        start_frame(2, 0, 1'b0);
        for (int k = 0; k < 40 && reads < 1; k++) tick();
        bus.entry_count_in = 9'd0;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        for (int k = 0; k < 40 && reads < 2; k++) tick();
        chk("busy_start_ignored", 32'(reads), 32'd2);
        tick();
        tick();
        chk("send_valid", 32'(bus.byte_valid_out), 32'd1);
        chk("send_byte", 32'(bus.byte_out), 32'h7A);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy_out), 32'd0);
        chk("arst_valid", 32'(bus.byte_valid_out), 32'd0);
        chk("arst_byte", 32'(bus.byte_out), 32'd0);
        chk("arst_read", 32'(bus.read_en_out), 32'd0);
        chk("arst_error", 32'(bus.error_out), 32'd0);
        q.delete();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("arst_no_done", 32'(dones - d0), 32'd0);
        chk("arst_idle", 32'(bus.busy_out), 32'd0);
        chk("arst_no_reads", 32'(reads), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
